// File: rtl/mem_ctrl_mmio.sv
// Wait-stated memory controller (MAR/MDR, IDLE/BUSY/DONE) with optional keyboard/display
// device registers, enabled by defining MEM_CTRL_MMIO_EN.
module mem_ctrl_mmio #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Bus,
  input  logic             ldMAR,
  input  logic             ldMDR,
  input  logic             mem_en,
  input  logic             memWE,
  output logic [WIDTH-1:0] MAROut,
  output logic [WIDTH-1:0] MDROut,
  output logic             R,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_data,
  output logic             kbd_ready,
  output logic             dsp_valid,
  output logic [7:0]       dsp_data,
  input  logic             dsp_ready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic [WIDTH-1:0] r_mar;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_ram [DEPTH];

  logic             w_idle;
  logic             w_exec;
  logic             w_isDev;
  logic             w_ramWe;
  logic [AW-1:0]    w_ramIdx;
  logic [WIDTH-1:0] w_rdData;

  assign w_idle   = (r_state == IDLE);
  assign w_exec   = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_ramIdx = r_mar[AW-1:0];
  assign w_ramWe  = w_exec && r_we && !w_isDev;

  assign MAROut = r_mar;
  assign MDROut = r_mdr;
  assign R      = (r_state == DONE);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (mem_en) w_nextState = BUSY;
      BUSY:    if (r_cnt == 4'd0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_idle && mem_en) begin
        r_cnt <= 4'(WAIT);
        r_we  <= memWE;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // MAR is frozen outside IDLE, so it doubles as the latched access address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else if (w_idle) begin
      if (ldMAR) r_mar <= Bus;
      if (ldMDR) r_mdr <= Bus;
    end else if (w_exec && !r_we) begin
      r_mdr <= w_rdData;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ramWe) r_ram[w_ramIdx] <= r_mdr;
  end

`ifdef MEM_CTRL_MMIO_EN
  logic       r_kbdFlag;
  logic [7:0] r_kbdByte;
  logic       r_dspValid;
  logic [7:0] r_dspData;
  logic       w_isKbsr;
  logic       w_isKbdr;
  logic       w_isDsr;
  logic       w_isDdr;

  assign w_isKbsr = (r_mar == WIDTH'(16'hFE00));
  assign w_isKbdr = (r_mar == WIDTH'(16'hFE02));
  assign w_isDsr  = (r_mar == WIDTH'(16'hFE04));
  assign w_isDdr  = (r_mar == WIDTH'(16'hFE06));
  assign w_isDev  = w_isKbsr || w_isKbdr || w_isDsr || w_isDdr;

  assign kbd_ready = ~r_kbdFlag;
  assign dsp_valid = r_dspValid;
  assign dsp_data  = r_dspData;

  always_comb begin
    w_rdData = r_ram[w_ramIdx];
    if (w_isKbsr)      w_rdData = {r_kbdFlag, {(WIDTH-1){1'b0}}};
    else if (w_isKbdr) w_rdData = {{(WIDTH-8){1'b0}}, r_kbdByte};
    else if (w_isDsr)  w_rdData = {~r_dspValid, {(WIDTH-1){1'b0}}};
    else if (w_isDdr)  w_rdData = {{(WIDTH-8){1'b0}}, r_dspData};
  end

  // A completing KBDR read beats a new keystroke; the flag was set, so ready was low anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kbdFlag  <= 1'b0;
      r_kbdByte  <= 8'h00;
      r_dspValid <= 1'b0;
      r_dspData  <= 8'h00;
    end else begin
      if (w_exec && !r_we && w_isKbdr) begin
        r_kbdFlag <= 1'b0;
      end else if (kbd_valid && !r_kbdFlag) begin
        r_kbdByte <= kbd_data;
        r_kbdFlag <= 1'b1;
      end
      if (w_exec && r_we && w_isDdr && !r_dspValid) begin
        r_dspData  <= r_mdr[7:0];
        r_dspValid <= 1'b1;
      end else if (r_dspValid && dsp_ready) begin
        r_dspValid <= 1'b0;
      end
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{kbd_valid, kbd_data, dsp_ready};
  assign w_isDev   = 1'b0;
  assign kbd_ready = 1'b0;
  assign dsp_valid = 1'b0;
  assign dsp_data  = 8'h00;

  always_comb begin
    w_rdData = r_ram[w_ramIdx];
  end
`endif

endmodule

// File: tb/tb_mem_ctrl_mmio.sv
// Directed self-checking bench for mem_ctrl_mmio: WAIT=2 main instance plus a WAIT=0
// instance for back-to-back timing. Device checks follow MEM_CTRL_MMIO_EN.
module tb_mem_ctrl_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus = '0;
  logic        ldMar = 1'b0, ldMdr = 1'b0, memEn = 1'b0, memWe = 1'b0;
  logic [15:0] marOut, mdrOut;
  logic        rOut, kbdReady, dspValid;
  logic        kbdValid = 1'b0, dspReady = 1'b0;
  logic [7:0]  kbdData = 8'h00, dspData;

  logic [15:0] bus0 = '0;
  logic        ldMar0 = 1'b0, memEn0 = 1'b0;
  logic [15:0] marOut0, mdrOut0;
  logic        rOut0, kbdReady0, dspValid0;
  logic [7:0]  dspData0;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_ctrl_mmio #(.WIDTH(16), .DEPTH(4096), .WAIT(2)) dut (
    .clk(clk), .reset(reset), .Bus(bus), .ldMAR(ldMar), .ldMDR(ldMdr),
    .mem_en(memEn), .memWE(memWe), .MAROut(marOut), .MDROut(mdrOut), .R(rOut),
    .kbd_valid(kbdValid), .kbd_data(kbdData), .kbd_ready(kbdReady),
    .dsp_valid(dspValid), .dsp_data(dspData), .dsp_ready(dspReady)
  );

  mem_ctrl_mmio #(.WIDTH(16), .DEPTH(4096), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .Bus(bus0), .ldMAR(ldMar0), .ldMDR(1'b0),
    .mem_en(memEn0), .memWE(1'b0), .MAROut(marOut0), .MDROut(mdrOut0), .R(rOut0),
    .kbd_valid(1'b0), .kbd_data(8'h00), .kbd_ready(kbdReady0),
    .dsp_valid(dspValid0), .dsp_data(dspData0), .dsp_ready(1'b0)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic loadMdr(input logic [15:0] value);
    @(negedge clk); bus = value; ldMdr = 1'b1;
    @(negedge clk); ldMdr = 1'b0;
  endtask

  // Loads MAR (and MDR for writes), issues the request on edge 0 and returns after edge 3.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input logic we,
                               output logic rEarly, output logic rAt);
    @(negedge clk); bus = addr; ldMar = 1'b1;
    @(negedge clk); ldMar = 1'b0;
    if (we) begin bus = data; ldMdr = 1'b1; end
    @(negedge clk); ldMdr = 1'b0; memEn = 1'b1; memWe = we;
    @(negedge clk); memEn = 1'b0; memWe = 1'b0;
    rEarly = rOut;
    @(negedge clk); rEarly = rEarly | rOut;
    @(negedge clk); rEarly = rEarly | rOut;
    @(negedge clk); rAt = rOut;
  endtask

  task automatic readWord(input logic [15:0] addr, input string tag, input logic [15:0] exp);
    logic e, a;
    loadMdr(16'h0000);
    applyStimulus(addr, 16'h0000, 1'b0, e, a);
    checkOutput({tag, "_R"}, {15'd0, a}, 16'h0001);
    checkOutput(tag, mdrOut, exp);
  endtask

  initial begin
    logic rEarly, rAt, sawR;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_MAR", marOut, 16'h0000);
    checkOutput("rst_MDR", mdrOut, 16'h0000);
    checkOutput("rst_R", {15'd0, rOut}, 16'h0000);
    checkOutput("rst_dspValid", {15'd0, dspValid}, 16'h0000);
    checkOutput("rst_dspData", {8'h00, dspData}, 16'h0000);
`ifdef MEM_CTRL_MMIO_EN
    checkOutput("rst_kbdReady", {15'd0, kbdReady}, 16'h0001);
`else
    checkOutput("rst_kbdReady", {15'd0, kbdReady}, 16'h0000);
`endif
    reset = 1'b0;

    // Basic write / read latency
    applyStimulus(16'h0010, 16'hBEEF, 1'b1, rEarly, rAt);
    checkOutput("wr_Rearly", {15'd0, rEarly}, 16'h0000);
    checkOutput("wr_Rat3", {15'd0, rAt}, 16'h0001);
    @(negedge clk);
    checkOutput("wr_Rafter", {15'd0, rOut}, 16'h0000);
    loadMdr(16'h0000);
    applyStimulus(16'h0010, 16'h0000, 1'b0, rEarly, rAt);
    checkOutput("rd_Rearly", {15'd0, rEarly}, 16'h0000);
    checkOutput("rd_Rat3", {15'd0, rAt}, 16'h0001);
    checkOutput("rd_data", mdrOut, 16'hBEEF);

    // Aliasing of high MAR bits
    applyStimulus(16'h1005, 16'h1234, 1'b1, rEarly, rAt);
    readWord(16'h0005, "alias_data", 16'h1234);
    checkOutput("alias_MAR", marOut, 16'h0005);

    // ldMAR together with mem_en: access uses the new address
    loadMdr(16'h0000);
    @(negedge clk); bus = 16'h0010; ldMar = 1'b1; memEn = 1'b1; memWe = 1'b0;
    @(negedge clk); ldMar = 1'b0; memEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sameCyc_R", {15'd0, rOut}, 16'h0001);
    checkOutput("sameCyc_data", mdrOut, 16'hBEEF);

    // Reset during BUSY aborts the write
    applyStimulus(16'h0020, 16'h0AAA, 1'b1, rEarly, rAt);
    @(negedge clk); bus = 16'h0020; ldMar = 1'b1;
    @(negedge clk); ldMar = 1'b0; bus = 16'h5555; ldMdr = 1'b1;
    @(negedge clk); ldMdr = 1'b0; memEn = 1'b1; memWe = 1'b1;
    @(negedge clk); memEn = 1'b0; memWe = 1'b0;
    sawR = rOut;
    @(negedge clk); sawR = sawR | rOut; reset = 1'b1;
    #1;
    checkOutput("abort_MAR", marOut, 16'h0000);
    checkOutput("abort_MDR", mdrOut, 16'h0000);
    checkOutput("abort_dspValid", {15'd0, dspValid}, 16'h0000);
    @(negedge clk); reset = 1'b0;
    repeat (4) begin @(negedge clk); sawR = sawR | rOut; end
    checkOutput("abort_noR", {15'd0, sawR}, 16'h0000);
    readWord(16'h0020, "abort_ram", 16'h0AAA);

    // WAIT=0 instance: IDLE->BUSY->DONE repeats every third cycle, ldMAR ignored when not IDLE
    @(negedge clk); bus0 = 16'h0003; ldMar0 = 1'b1; memEn0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("w0_R_%0d", k), {15'd0, rOut0}, (k % 3 == 1) ? 16'h0001 : 16'h0000);
      bus0 = 16'hFFFF;
      ldMar0 = (k % 3 != 2);
      @(negedge clk);
    end
    memEn0 = 1'b0; ldMar0 = 1'b0;
    checkOutput("w0_MAR", marOut0, 16'h0003);

`ifdef MEM_CTRL_MMIO_EN
    applyStimulus(16'h0E06, 16'h7777, 1'b1, rEarly, rAt);
    // Keyboard
    @(negedge clk); kbdValid = 1'b1; kbdData = 8'h41;
    @(negedge clk); kbdData = 8'h42;
    checkOutput("kbd_readyLow", {15'd0, kbdReady}, 16'h0000);
    readWord(16'hFE00, "kbd_KBSR", 16'h8000);
    readWord(16'hFE02, "kbd_KBDR", 16'h0041);
    checkOutput("kbd_cleared", {15'd0, kbdReady}, 16'h0001);
    kbdValid = 1'b0;
    readWord(16'hFE00, "kbd_KBSR2", 16'h0000);
    readWord(16'hFE02, "kbd_KBDR2", 16'h0041);
    // Display
    applyStimulus(16'hFE06, 16'h0058, 1'b1, rEarly, rAt);
    checkOutput("dsp_valid", {15'd0, dspValid}, 16'h0001);
    checkOutput("dsp_data", {8'h00, dspData}, 16'h0058);
    applyStimulus(16'hFE06, 16'h0059, 1'b1, rEarly, rAt);
    checkOutput("dsp_dropR", {15'd0, rAt}, 16'h0001);
    checkOutput("dsp_dropData", {8'h00, dspData}, 16'h0058);
    readWord(16'hFE04, "dsp_DSRbusy", 16'h0000);
    readWord(16'hFE06, "dsp_DDR", 16'h0058);
    @(negedge clk); dspReady = 1'b1;
    @(negedge clk); dspReady = 1'b0;
    checkOutput("dsp_consumed", {15'd0, dspValid}, 16'h0000);
    readWord(16'hFE04, "dsp_DSRfree", 16'h8000);
    readWord(16'h0E06, "dsp_ramUntouched", 16'h7777);
`else
    applyStimulus(16'hFE06, 16'h4321, 1'b1, rEarly, rAt);
    checkOutput("noMmio_dspValid", {15'd0, dspValid}, 16'h0000);
    checkOutput("noMmio_kbdReady", {15'd0, kbdReady}, 16'h0000);
    readWord(16'h0E06, "noMmio_alias", 16'h4321);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
